pu_sequencer: RTL

- Drives one 4-input processing unit (PU: 4 fp multipliers, registered; 3-adder tree, registered; combinational activation) through a full layer of NUM_NEURONS neurons.
- Latches one shared activation vector at start, fetches one 4-weight word per neuron from a synchronous weight memory, and presents operands to the PU.
- Tracks each issued neuron through the PU's fixed 2-register latency and captures pu_out into a result FIFO.
- Streams results out on a valid/ready interface, with credit-based issue throttling so no result is ever dropped.

---
 rtl/pu_sequencer_pkg.sv | 14 +
 rtl/pu_sequencer_res_fifo.sv | 47 ++++
 rtl/pu_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pu_sequencer_pkg.sv
// rtl/pu_sequencer_pkg.sv - shared FSM encoding, PU latency and float constants for pu_sequencer
package pu_sequencer_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // Registers between stable PU inputs and a valid pu_out (multiply reg, adder-tree reg)
   localparam int PU_LATENCY = 2;

   localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
   localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/pu_sequencer_res_fifo.sv
// rtl/pu_sequencer_res_fifo.sv - synchronous result FIFO holding {data, neuron index}
module res_fifo #(
   parameter int W     = 36,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               wdata,
   input  logic                       pop,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == ($clog2(DEPTH)+1)'(DEPTH));

endmodule

// File: rtl/pu_sequencer.sv
// rtl/pu_sequencer.sv - issues one layer of neurons through a 4-input PU and streams the results
module pu_sequencer
   import pu_sequencer_pkg::*;
#(
   parameter int DW          = 32,
   parameter int NUM_NEURONS = 16,
   parameter int FIFO_DEPTH  = 8,
   parameter int AW          = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [4*DW-1:0] a_in,
   output logic            busy,
   output logic            done,
   output logic            w_ren,
   output logic [AW-1:0]   w_addr,
   input  logic [4*DW-1:0] w_rdata,
   output logic [DW-1:0]   pu_a1,
   output logic [DW-1:0]   pu_a2,
   output logic [DW-1:0]   pu_a3,
   output logic [DW-1:0]   pu_a4,
   output logic [DW-1:0]   pu_w1,
   output logic [DW-1:0]   pu_w2,
   output logic [DW-1:0]   pu_w3,
   output logic [DW-1:0]   pu_w4,
   input  logic [DW-1:0]   pu_out,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [DW-1:0]   res_data,
   output logic [AW-1:0]   res_idx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]        state;
   logic [AW-1:0]     issue_cnt;
   logic [4*DW-1:0]   a_lat;
   logic [CW-1:0]     inflight;
   logic [CW-1:0]     fifo_count;
   logic              fifo_empty;
   logic              fifo_full;
   logic [DW+AW-1:0]  head;
   logic              credit, issue, push, pop, last_issue;

   logic                  rd_v, op_v;
   logic [AW-1:0]         rd_idx, op_idx;
   logic [PU_LATENCY-1:0] pl_v;
   logic [AW-1:0]         pl_idx [PU_LATENCY];

   // Every issued neuron owns a FIFO slot until popped, so a push can never find the FIFO full
   assign credit     = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
   assign issue      = (state == ST_ISSUE) && credit;
   assign last_issue = (issue_cnt == AW'(NUM_NEURONS - 1));
   assign push       = pl_v[PU_LATENCY-1];
   assign pop        = res_valid && res_ready;

   assign w_ren     = issue;
   assign w_addr    = issue_cnt;
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DRAIN) && pop && (inflight == '0) && (fifo_count == CW'(1));
   assign res_valid = !fifo_empty;
   assign res_data  = fifo_empty ? '0 : head[DW+AW-1:AW];
   assign res_idx   = fifo_empty ? '0 : head[AW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         issue_cnt <= '0;
         a_lat     <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               a_lat     <= a_in;
               issue_cnt <= '0;
               state     <= ST_ISSUE;
            end
            ST_ISSUE: if (issue) begin
               issue_cnt <= issue_cnt + 1'b1;
               if (last_issue) state <= ST_DRAIN;
            end
            ST_DRAIN: if (done) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight <= '0;
      end else begin
         case ({issue, push})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
      end
   end

   // Tags mirror the PU pipeline; cleared tags mask stale PU output after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_v   <= 1'b0;
         op_v   <= 1'b0;
         rd_idx <= '0;
         op_idx <= '0;
         pl_v   <= '0;
         for (int i = 0; i < PU_LATENCY; i++) pl_idx[i] <= '0;
      end else begin
         rd_v      <= issue;
         rd_idx    <= issue_cnt;
         op_v      <= rd_v;
         op_idx    <= rd_idx;
         pl_v[0]   <= op_v;
         pl_idx[0] <= op_idx;
         for (int i = 1; i < PU_LATENCY; i++) begin
            pl_v[i]   <= pl_v[i-1];
            pl_idx[i] <= pl_idx[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pu_a1 <= '0; pu_a2 <= '0; pu_a3 <= '0; pu_a4 <= '0;
         pu_w1 <= '0; pu_w2 <= '0; pu_w3 <= '0; pu_w4 <= '0;
      end else if (rd_v) begin
         pu_a1 <= a_lat[DW-1:0];
         pu_a2 <= a_lat[2*DW-1:DW];
         pu_a3 <= a_lat[3*DW-1:2*DW];
         pu_a4 <= a_lat[4*DW-1:3*DW];
         pu_w1 <= w_rdata[DW-1:0];
         pu_w2 <= w_rdata[2*DW-1:DW];
         pu_w3 <= w_rdata[3*DW-1:2*DW];
         pu_w4 <= w_rdata[4*DW-1:3*DW];
      end
   end

   res_fifo #(
      .W     (DW + AW),
      .DEPTH (FIFO_DEPTH)
   ) u_res_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({pu_out, pl_idx[PU_LATENCY-1]}),
      .pop   (pop),
      .rdata (head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule
